// File: rtl/axi_read_arbiter_if.sv
// AXI4 read-channel bundle (AR + R) shared by the arbiter's two master ports and its RAM port.
// master modport drives AR and rready; slave modport drives arready and the R payload.
interface axi_read_arbiter_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256
);
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Two-master AXI4 read arbiter: one whole burst at a time, R routed to the owner, beat count checked.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is fixed priority to master 0.
module axi_read_arbiter #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axi_read_arbiter_if.slave    m0_axi,
    axi_read_arbiter_if.slave    m1_axi,
    axi_read_arbiter_if.master   s_axi,
    output logic                 busy,
    output logic                 grant,
    output logic                 len_err
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } state_t;

    state_t          state_q;
    logic            grant_q;
    logic            busy_q;
    logic            len_err_q;
    logic [7:0]      exp_len_q;
    logic [8:0]      beat_cnt_q;

    logic            req_any;
    logic            winner;
    logic [7:0]      win_arlen;
    logic            ar_phase;
    logic            r_phase;
    logic            ar_hs;
    logic            r_hs;
    logic            sel_arvalid;
    logic            sel_rready;
    logic            cnt_mismatch;

    logic [ID_WIDTH-1:0]   arid_sel;
    logic [ADDR_WIDTH-1:0] araddr_sel;
    logic [ID_WIDTH-1:0]   rid_fan;
    logic [DATA_WIDTH-1:0] rdata_fan;

    assign req_any = m0_axi.arvalid | m1_axi.arvalid;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_ptr_q;

    assign winner = (m0_axi.arvalid & m1_axi.arvalid) ? rr_ptr_q : ~m0_axi.arvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
        end else if (r_hs && s_axi.rlast) begin
            rr_ptr_q <= ~grant_q;
        end
    end
`else
    assign winner = ~m0_axi.arvalid;
`endif

    assign win_arlen = winner ? m1_axi.arlen : m0_axi.arlen;

    // Compare in 10 bits so a saturated count of 256 still mismatches any legal arlen.
    assign cnt_mismatch = ({1'b0, beat_cnt_q} + 10'd1) != ({2'b00, exp_len_q} + 10'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            busy_q     <= 1'b0;
            len_err_q  <= 1'b0;
            exp_len_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    beat_cnt_q <= '0;
                    if (req_any) begin
                        state_q   <= AR;
                        busy_q    <= 1'b1;
                        grant_q   <= winner;
                        exp_len_q <= win_arlen;
                    end
                end
                AR: begin
                    if (ar_hs) begin
                        state_q <= R;
                    end
                end
                R: begin
                    if (r_hs) begin
                        if (beat_cnt_q != 9'd256) begin
                            beat_cnt_q <= beat_cnt_q + 9'd1;
                        end
                        if (s_axi.rlast) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            if (cnt_mismatch) begin
                                len_err_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ar_phase = (state_q == AR);
    assign r_phase  = (state_q == R);

    assign sel_arvalid = grant_q ? m1_axi.arvalid : m0_axi.arvalid;
    assign sel_rready  = grant_q ? m1_axi.rready  : m0_axi.rready;

    assign arid_sel   = grant_q ? m1_axi.arid   : m0_axi.arid;
    assign araddr_sel = grant_q ? m1_axi.araddr : m0_axi.araddr;

    assign s_axi.arid    = arid_sel;
    assign s_axi.araddr  = araddr_sel;
    assign s_axi.arlen   = grant_q ? m1_axi.arlen   : m0_axi.arlen;
    assign s_axi.arsize  = grant_q ? m1_axi.arsize  : m0_axi.arsize;
    assign s_axi.arburst = grant_q ? m1_axi.arburst : m0_axi.arburst;
    assign s_axi.arvalid = ar_phase & sel_arvalid;
    assign s_axi.rready  = r_phase & sel_rready;

    assign m0_axi.arready = ar_phase & ~grant_q & s_axi.arready;
    assign m1_axi.arready = ar_phase &  grant_q & s_axi.arready;

    assign ar_hs = s_axi.arvalid & s_axi.arready;
    assign r_hs  = s_axi.rvalid & s_axi.rready;

    // R payload goes to both masters; only the owner's rvalid qualifies it.
    assign rid_fan   = s_axi.rid;
    assign rdata_fan = s_axi.rdata;

    assign m0_axi.rid    = rid_fan;
    assign m0_axi.rdata  = rdata_fan;
    assign m0_axi.rresp  = s_axi.rresp;
    assign m0_axi.rlast  = s_axi.rlast;
    assign m0_axi.rvalid = r_phase & ~grant_q & s_axi.rvalid;

    assign m1_axi.rid    = rid_fan;
    assign m1_axi.rdata  = rdata_fan;
    assign m1_axi.rresp  = s_axi.rresp;
    assign m1_axi.rlast  = s_axi.rlast;
    assign m1_axi.rvalid = r_phase &  grant_q & s_axi.rvalid;

    assign busy    = busy_q;
    assign grant   = grant_q;
    assign len_err = len_err_q;
endmodule
